// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX write-request arbiter and its picker.
package tx_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DATA} arb_state_t;

  localparam int C_BEAT_DW   = 4;
  localparam int C_MAX_BEATS = 256;

  // Channel index width; never below 1 so a single-port build still has a bus.
  function automatic int clog2s(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Dword length to 128-bit beat count; a length of 0 encodes 1024 dwords.
  function automatic logic [8:0] len_to_beats(input logic [9:0] len);
    if (len == '0) return 9'(C_MAX_BEATS);
    return 9'((int'(len) + C_BEAT_DW - 1) / C_BEAT_DW);
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Rotating-priority picker: first set request strictly after i_last (mod N).
module tx_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic         o_vld,
  output logic [W-1:0] o_idx
);

  int p;

  // Scan farthest-first so the nearest requester after i_last overwrites.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    p     = 0;
    for (int k = N; k >= 1; k--) begin
      p = (int'(i_last) + k) % N;
      if (i_req[p]) begin
        o_vld = 1'b1;
        o_idx = W'(p);
      end
    end
  end

endmodule

// File: rtl/tx_write_req_arbiter_128.sv
// Rotating-priority arbiter from C_NUM_CHNL 128-bit TX ports to one engine write port.
// Optional protocol checker (ERR/ERR_CHNL) built when TX_ARB_PROTOCOL_CHECK_EN is defined.
module tx_write_req_arbiter_128
  import tx_arb_pkg::*;
#(
  parameter int C_NUM_CHNL   = 4,
  parameter int C_DATA_WIDTH = 128,
  parameter int C_CHNL_WIDTH = clog2s(C_NUM_CHNL)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [C_NUM_CHNL-1:0]            CH_TX_REQ,
  output logic [C_NUM_CHNL-1:0]            CH_TX_REQ_ACK,
  input  logic [64*C_NUM_CHNL-1:0]         CH_TX_ADDR,
  input  logic [10*C_NUM_CHNL-1:0]         CH_TX_LEN,
  input  logic [C_DATA_WIDTH*C_NUM_CHNL-1:0] CH_TX_DATA,
  output logic [C_NUM_CHNL-1:0]            CH_TX_DATA_REN,
  output logic [C_NUM_CHNL-1:0]            CH_TX_SENT,
  output logic                             WR_REQ,
  input  logic                             WR_REQ_ACK,
  output logic [C_CHNL_WIDTH-1:0]          WR_CHNL,
  output logic [63:0]                      WR_ADDR,
  output logic [9:0]                       WR_LEN,
  output logic [C_DATA_WIDTH-1:0]          WR_DATA,
  input  logic                             WR_DATA_REN,
  input  logic                             WR_SENT
`ifdef TX_ARB_PROTOCOL_CHECK_EN
  ,
  output logic                             ERR,
  output logic [C_CHNL_WIDTH-1:0]          ERR_CHNL
`endif
);

  logic [C_NUM_CHNL-1:0][63:0]             w_addr_a;
  logic [C_NUM_CHNL-1:0][9:0]              w_len_a;
  logic [C_NUM_CHNL-1:0][C_DATA_WIDTH-1:0] w_data_a;

  assign w_addr_a = CH_TX_ADDR;
  assign w_len_a  = CH_TX_LEN;
  assign w_data_a = CH_TX_DATA;

  arb_state_t              r_state, w_state_nxt;
  logic [C_CHNL_WIDTH-1:0] r_sel, r_last_grant;
  logic [8:0]              r_beats;
  logic [63:0]             r_wr_addr;
  logic [9:0]              r_wr_len;
  logic                    w_pick_vld;
  logic [C_CHNL_WIDTH-1:0] w_pick_idx;
  logic                    w_ren;

  tx_rr_pick #(.N(C_NUM_CHNL), .W(C_CHNL_WIDTH)) u_pick (
    .i_req  (CH_TX_REQ),
    .i_last (r_last_grant),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  // Beats past the granted length are swallowed so the port never over-reads.
  assign w_ren = (r_state == DATA) && WR_DATA_REN && (r_beats != '0);

  always_comb begin
    w_state_nxt    = r_state;
    CH_TX_REQ_ACK  = '0;
    CH_TX_DATA_REN = '0;
    CH_TX_SENT     = '0;
    WR_DATA        = '0;
    case (r_state)
      IDLE: if (w_pick_vld) w_state_nxt = REQ;
      REQ: if (WR_REQ_ACK) begin
        CH_TX_REQ_ACK[r_sel] = 1'b1;
        w_state_nxt          = DATA;
      end
      DATA: begin
        WR_DATA               = w_data_a[r_sel];
        CH_TX_DATA_REN[r_sel] = w_ren;
        if (WR_SENT) begin
          CH_TX_SENT[r_sel] = 1'b1;
          w_state_nxt       = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_last_grant <= C_CHNL_WIDTH'(C_NUM_CHNL - 1);
      r_beats      <= '0;
      r_wr_addr    <= '0;
      r_wr_len     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_vld) begin
        r_sel        <= w_pick_idx;
        r_last_grant <= w_pick_idx;
        r_wr_addr    <= w_addr_a[w_pick_idx];
        r_wr_len     <= w_len_a[w_pick_idx];
        r_beats      <= len_to_beats(w_len_a[w_pick_idx]);
      end else if (w_ren) begin
        r_beats <= r_beats - 9'd1;
      end
    end
  end

  assign WR_REQ  = (r_state == REQ);
  assign WR_CHNL = r_sel;
  assign WR_ADDR = r_wr_addr;
  assign WR_LEN  = r_wr_len;

`ifdef TX_ARB_PROTOCOL_CHECK_EN
  logic                    r_err;
  logic [C_CHNL_WIDTH-1:0] r_err_chnl;
  logic [8:0]              w_beats_left;
  logic                    w_err_evt;

  // A SENT coinciding with the final beat is legal, so judge it after this cycle's beat.
  assign w_beats_left = r_beats - {8'd0, w_ren};
  assign w_err_evt    = ((r_state == DATA) && WR_DATA_REN && (r_beats == '0)) ||
                        (WR_SENT && (w_beats_left != '0)) ||
                        (WR_REQ_ACK && (r_state != REQ));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err      <= 1'b0;
      r_err_chnl <= '0;
    end else if (w_err_evt && !r_err) begin
      r_err      <= 1'b1;
      r_err_chnl <= r_sel;
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK)
    if (!RST && w_err_evt) $error("tx arbiter protocol error on channel %0d", r_sel);
`endif

  assign ERR      = r_err;
  assign ERR_CHNL = r_err_chnl;
`endif

endmodule

// File: tb/tb_tx_write_req_arbiter_128.sv
// Self-checking bench: vector table, hand-written corner sequences and a randomized run vs. a rule model.
module tb_tx_write_req_arbiter_128;
  localparam int N = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      CH_TX_REQ, CH_TX_REQ_ACK, CH_TX_DATA_REN, CH_TX_SENT;
  logic [64*N-1:0]   CH_TX_ADDR;
  logic [10*N-1:0]   CH_TX_LEN;
  logic [128*N-1:0]  CH_TX_DATA;
  logic              WR_REQ, WR_REQ_ACK, WR_DATA_REN, WR_SENT;
  logic [1:0]        WR_CHNL;
  logic [63:0]       WR_ADDR;
  logic [9:0]        WR_LEN;
  logic [127:0]      WR_DATA;
`ifdef TX_ARB_PROTOCOL_CHECK_EN
  logic              ERR;
  logic [1:0]        ERR_CHNL;
`endif

  int checks = 0, failures = 0;

  tx_write_req_arbiter_128 #(.C_NUM_CHNL(N)) dut (
    .CLK(CLK), .RST(RST), .CH_TX_REQ(CH_TX_REQ), .CH_TX_REQ_ACK(CH_TX_REQ_ACK),
    .CH_TX_ADDR(CH_TX_ADDR), .CH_TX_LEN(CH_TX_LEN), .CH_TX_DATA(CH_TX_DATA),
    .CH_TX_DATA_REN(CH_TX_DATA_REN), .CH_TX_SENT(CH_TX_SENT), .WR_REQ(WR_REQ),
    .WR_REQ_ACK(WR_REQ_ACK), .WR_CHNL(WR_CHNL), .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN),
    .WR_DATA(WR_DATA), .WR_DATA_REN(WR_DATA_REN), .WR_SENT(WR_SENT)
`ifdef TX_ARB_PROTOCOL_CHECK_EN
    , .ERR(ERR), .ERR_CHNL(ERR_CHNL)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int beats_of(input logic [9:0] l);
    return (l == 0) ? 256 : (int'(l) + 3) / 4;
  endfunction

  task automatic set_port(input int p, input logic [9:0] l, input logic [63:0] a);
    CH_TX_LEN[10*p +: 10]  = l;
    CH_TX_ADDR[64*p +: 64] = a;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // One full write from an idle arbiter; one extra REN is offered past the end.
  task automatic do_write(input int p, input logic [9:0] l, input logic [63:0] a, input int beats);
    int cnt;
    logic [N-1:0] other;
    logic [127:0] d;
    CH_TX_REQ = oh(p);
    set_port(p, l, a);
    d = rnd128();
    CH_TX_DATA[128*p +: 128] = d;
    step();
    CH_TX_REQ = '0;
    chk("grant_req", WR_REQ, 1);
    chk("grant_chnl", WR_CHNL, p);
    chk("grant_addr", WR_ADDR, a);
    chk("grant_len", WR_LEN, l);
    WR_REQ_ACK = 1'b1;
    #1 chk("ack_route", CH_TX_REQ_ACK, oh(p));
    step();
    WR_REQ_ACK = 1'b0;
    chk("req_drop", WR_REQ, 0);
    cnt = 0;
    other = '0;
    for (int i = 0; i <= beats; i++) begin
      WR_DATA_REN = 1'b1;
      #1;
      if (i == 0) chk("data_mux", WR_DATA, d);
      if (i == beats) chk("overread_block", CH_TX_DATA_REN, 0);
      cnt += int'(CH_TX_DATA_REN[p]);
      other |= CH_TX_DATA_REN & ~oh(p);
      step();
    end
    WR_DATA_REN = 1'b0;
    WR_SENT = 1'b1;
    #1 chk("sent_route", CH_TX_SENT, oh(p));
    step();
    WR_SENT = 1'b0;
    chk("beat_count", cnt, beats);
    chk("ren_other_ports", other, 0);
  endtask

  typedef struct {
    int          port;
    logic [9:0]  len;
    logic [63:0] addr;
    int          beats;
  } vec_t;
  vec_t tbl[6];

  // Behavioural reference: phase 0 idle, 1 request, 2 data.
  int          m_phase, m_sel, m_last, m_left;
  logic [63:0] m_addr;
  logic [9:0]  m_len;

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_last = N - 1; m_left = 0; m_addr = '0; m_len = '0;
  endtask

  task automatic model_advance();
    int pick;
    pick = -1;
    case (m_phase)
      0: begin
        for (int k = 1; k <= N; k++)
          if (pick < 0 && CH_TX_REQ[(m_last + k) % N]) pick = (m_last + k) % N;
        if (pick >= 0) begin
          m_sel   = pick;
          m_last  = pick;
          m_addr  = CH_TX_ADDR[64*pick +: 64];
          m_len   = CH_TX_LEN[10*pick +: 10];
          m_left  = beats_of(m_len);
          m_phase = 1;
        end
      end
      1: if (WR_REQ_ACK) m_phase = 2;
      default: begin
        if (WR_DATA_REN && m_left > 0) m_left--;
        if (WR_SENT) m_phase = 0;
      end
    endcase
  endtask

  initial begin
    tbl[0] = '{2, 10'd10,   64'h0000_0001_0000_00A0, 3};
    tbl[1] = '{0, 10'd1,    64'hFFFF_FFFF_FFFF_FFF0, 1};
    tbl[2] = '{3, 10'd0,    64'h0000_0000_DEAD_B000, 256};
    tbl[3] = '{1, 10'd1023, 64'h1234_5678_9ABC_DEF0, 256};
    tbl[4] = '{1, 10'd8,    64'h0000_0000_0000_1000, 2};
    tbl[5] = '{0, 10'd5,    64'h8000_0000_0000_0004, 2};

    CH_TX_REQ = '0; CH_TX_ADDR = '0; CH_TX_LEN = '0; CH_TX_DATA = '0;
    WR_REQ_ACK = 1'b0; WR_DATA_REN = 1'b0; WR_SENT = 1'b0;
    RST = 1'b1;
    step();
    step();
    chk("rst_wr_req", WR_REQ, 0);
    chk("rst_wr_addr", WR_ADDR, 0);
    chk("rst_wr_len", WR_LEN, 0);
    chk("rst_wr_chnl", WR_CHNL, 0);
    chk("rst_ch_out", {CH_TX_REQ_ACK, CH_TX_DATA_REN, CH_TX_SENT}, 0);
    RST = 1'b0;

    foreach (tbl[i]) do_write(tbl[i].port, tbl[i].len, tbl[i].addr, tbl[i].beats);
`ifdef TX_ARB_PROTOCOL_CHECK_EN
    chk("err_overread", ERR, 1);
    chk("err_chnl", ERR_CHNL, 2);
`endif

    // Round robin among ports 0,1,3 requesting continuously, one beat each.
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 10'd4, 64'(p * 16));
    CH_TX_REQ = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      step();
      chk("rr_req", WR_REQ, 1);
      chk("rr_order", WR_CHNL, (g % 3 == 2) ? 3 : g % 3);
      WR_REQ_ACK = 1'b1;
      step();
      WR_REQ_ACK = 1'b0;
      WR_DATA_REN = 1'b1; WR_SENT = 1'b1;
      step();
      WR_DATA_REN = 1'b0; WR_SENT = 1'b0;
    end
    CH_TX_REQ = '0;

    // SENT together with the last beat, then back-to-back grant.
    CH_TX_REQ = oh(1);
    set_port(1, 10'd8, 64'h40);
    step();
    CH_TX_REQ = '0;
    chk("b2b_chnl1", WR_CHNL, 1);
    WR_REQ_ACK = 1'b1;
    step();
    WR_REQ_ACK = 1'b0;
    WR_DATA_REN = 1'b1;
    #1 chk("b2b_beat1", CH_TX_DATA_REN, oh(1));
    step();
    WR_SENT = 1'b1;
    #1 chk("b2b_last_ren", CH_TX_DATA_REN, oh(1));
    chk("b2b_sent", CH_TX_SENT, oh(1));
    CH_TX_REQ = oh(2);
    set_port(2, 10'd4, 64'h80);
    step();
    WR_DATA_REN = 1'b0; WR_SENT = 1'b0;
    chk("b2b_idle", WR_REQ, 0);
    step();
    CH_TX_REQ = '0;
    chk("b2b_next_req", WR_REQ, 1);
    chk("b2b_next_chnl", WR_CHNL, 2);
    WR_REQ_ACK = 1'b1;
    step();
    WR_REQ_ACK = 1'b0; WR_DATA_REN = 1'b1; WR_SENT = 1'b1;
    step();
    WR_DATA_REN = 1'b0; WR_SENT = 1'b0;

    // Reset in DATA with 5 beats left; priority restarts at port 0.
    CH_TX_REQ = oh(3);
    set_port(3, 10'd40, 64'hC0);
    set_port(0, 10'd4, 64'h10);
    step();
    CH_TX_REQ = '0;
    WR_REQ_ACK = 1'b1;
    step();
    WR_REQ_ACK = 1'b0;
    WR_DATA_REN = 1'b1;
    repeat (5) step();
    RST = 1'b1;
    CH_TX_REQ = 4'b1001;
    step();
    chk("rst_mid_req", WR_REQ, 0);
    chk("rst_mid_regs", {WR_ADDR, WR_LEN, WR_CHNL}, 0);
    chk("rst_mid_ch", {CH_TX_REQ_ACK, CH_TX_DATA_REN, CH_TX_SENT}, 0);
    RST = 1'b0;
    WR_DATA_REN = 1'b0;
    step();
    CH_TX_REQ = '0;
    chk("rst_prio_chnl", WR_CHNL, 0);
    WR_REQ_ACK = 1'b1;
    step();
    WR_REQ_ACK = 1'b0; WR_DATA_REN = 1'b1; WR_SENT = 1'b1;
    step();
    WR_DATA_REN = 1'b0; WR_SENT = 1'b0;

    // Stray ACK in IDLE and stray SENT in REQ.
    WR_REQ_ACK = 1'b1;
    #1 chk("stray_ack_route", CH_TX_REQ_ACK, 0);
    step();
    WR_REQ_ACK = 1'b0;
    chk("stray_ack_state", WR_REQ, 0);
    CH_TX_REQ = oh(1);
    set_port(1, 10'd4, 64'h20);
    step();
    CH_TX_REQ = '0;
    WR_SENT = 1'b1;
    #1 chk("stray_sent_route", CH_TX_SENT, 0);
    step();
    WR_SENT = 1'b0;
    chk("stray_sent_state", WR_REQ, 1);
    WR_REQ_ACK = 1'b1;
    step();
    WR_REQ_ACK = 1'b0; WR_DATA_REN = 1'b1; WR_SENT = 1'b1;
    step();
    WR_DATA_REN = 1'b0; WR_SENT = 1'b0;
`ifdef TX_ARB_PROTOCOL_CHECK_EN
    chk("err_sticky", ERR, 1);
`endif

    // Randomized legal traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < N; p++) begin
        CH_TX_REQ[p] = ($urandom_range(0, 3) == 0);
        set_port(p, ($urandom_range(0, 15) == 0) ? 10'd0 : 10'($urandom_range(1, 64)), {$urandom, $urandom});
        CH_TX_DATA[128*p +: 128] = rnd128();
      end
      WR_REQ_ACK  = (m_phase == 1) && ($urandom_range(0, 1) == 1);
      WR_DATA_REN = (m_phase == 2) && (m_left > 0) && ($urandom_range(0, 3) != 0);
      WR_SENT     = (m_phase == 2) && (m_left - int'(WR_DATA_REN) == 0) && ($urandom_range(0, 1) == 1);
      #1;
      chk("rnd_wr_req", WR_REQ, m_phase == 1);
      chk("rnd_regs", {WR_CHNL, WR_ADDR, WR_LEN}, {2'(m_sel), m_addr, m_len});
      chk("rnd_ack", CH_TX_REQ_ACK, (m_phase == 1 && WR_REQ_ACK) ? oh(m_sel) : '0);
      chk("rnd_ren", CH_TX_DATA_REN, (m_phase == 2 && WR_DATA_REN && m_left > 0) ? oh(m_sel) : '0);
      chk("rnd_sent", CH_TX_SENT, (m_phase == 2 && WR_SENT) ? oh(m_sel) : '0);
      if (m_phase == 2) chk("rnd_data", WR_DATA, CH_TX_DATA[128*m_sel +: 128]);
      model_advance();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
